// File: rtl/mfsk_pkg.sv
// Shared state type, reset-table defaults and Gray decode helper for the
// M-ary FSK modulator.
package mfsk_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_BASE_DIV = 2;
    localparam int DEFAULT_STEP_DIV = 1;

    // Width-generic: bits above the caller's symbol width must be zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/mfsk_tone_gen.sv
// Square-wave tone generator: half-period counter with a >= compare so a
// divider lowered below the running count toggles next cycle instead of wrapping.
module mfsk_tone_gen
    import mfsk_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             enable,
    input  logic             restart,
    output logic             fsk_out
);

    logic [DIV_W-1:0] r_tcnt;
    logic             r_fsk;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_fsk  <= 1'b0;
        end else if (restart) begin
            // New symbol: restart the half-period but hold the level.
            r_tcnt <= '0;
        end else if (!enable) begin
            r_tcnt <= '0;
            r_fsk  <= 1'b0;
        end else if (r_tcnt >= div) begin
            r_tcnt <= '0;
            r_fsk  <= ~r_fsk;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign fsk_out = r_fsk;

endmodule

// File: rtl/mfsk_mod.sv
// M-ary FSK modulator top: symbol handshake, symbol-length counter, tone table.
// Optional macro MFSK_GRAY_EN Gray-decodes the accepted symbol before use.
module mfsk_mod
    import mfsk_pkg::*;
#(
    parameter int BITS_PER_SYM = 1,
    parameter int DIV_W        = 8,
    parameter int LEN_W        = 16,
    parameter int BASE_DIV     = DEFAULT_BASE_DIV,
    parameter int STEP_DIV     = DEFAULT_STEP_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BITS_PER_SYM-1:0] sym_in,
    input  logic                    sym_valid,
    input  logic [LEN_W-1:0]        sym_len,
    output logic                    sym_ready,
    input  logic                    cfg_we,
    input  logic [BITS_PER_SYM-1:0] cfg_addr,
    input  logic [DIV_W-1:0]        cfg_div,
    output logic                    fsk_out,
    output logic [BITS_PER_SYM-1:0] tone_idx,
    output logic                    busy,
    output logic                    underrun
);

    localparam int M = 1 << BITS_PER_SYM;

    state_t                  r_state;
    logic [LEN_W-1:0]        r_scnt;
    logic [LEN_W-1:0]        r_len;
    logic [BITS_PER_SYM-1:0] r_tone;
    logic                    r_underrun;
    logic [DIV_W-1:0]        r_div [M];

    logic                    w_last;
    logic                    w_accept;
    logic                    w_run_next;
    logic [BITS_PER_SYM-1:0] w_sym_tone;

    assign w_last     = (r_state == RUN) && (r_scnt == r_len);
    assign sym_ready  = (r_state == IDLE) || w_last;
    assign w_accept   = sym_valid && sym_ready;
    assign w_run_next = w_accept || ((r_state == RUN) && !w_last);

`ifdef MFSK_GRAY_EN
    assign w_sym_tone = BITS_PER_SYM'(gray2bin(32'(sym_in)));
`else
    assign w_sym_tone = sym_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_scnt     <= '0;
            r_len      <= '0;
            r_tone     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_accept) begin
                r_state <= RUN;
                r_scnt  <= '0;
                r_len   <= sym_len;
                r_tone  <= w_sym_tone;
            end else if (w_last) begin
                r_state    <= IDLE;
                r_scnt     <= '0;
                r_underrun <= 1'b1;
            end else if (r_state == RUN) begin
                r_scnt <= r_scnt + 1'b1;
            end
        end
    end

    // NOTE: the tone table is a small register file, not RAM, so it is reset
    // to its defined power-up tones like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                r_div[i] <= DIV_W'(BASE_DIV + i * STEP_DIV);
            end
        end else if (cfg_we) begin
            r_div[cfg_addr] <= cfg_div;
        end
    end

    mfsk_tone_gen #(
        .DIV_W (DIV_W)
    ) u_tone_gen (
        .clk     (clk),
        .rst     (rst),
        .div     (r_div[r_tone]),
        .enable  (w_run_next),
        .restart (w_accept),
        .fsk_out (fsk_out)
    );

    assign tone_idx = r_tone;
    assign busy     = (r_state == RUN);
    assign underrun = r_underrun;

endmodule
